ln_sub_norm: RTL and testbench
==============================

Name: ln_sub_norm

Overview:
- Log-domain softmax normaliser. Sits directly downstream of the ln stage.
- Buffers one vector of max-subtracted logits (x_i − max, Q7.8 signed) while the exp-sum and ln are computed.
- Once ln(sum) arrives (Q7.8 signed), streams out y_i = (x_i − max) − ln(sum) in Q7.8 for the downstream exp stage.
- Both input streams and the output stream are valid/ready handshakes.

Parameters:
- VEC_LEN, 64, maximum elements per vector; sets buffer depth.
- ADDR_W, 6, buffer index width; must equal ceil(log2(VEC_LEN)).

Ports:
- iClk  in  1  clock, all logic on rising edge
- iRst  in  1  reset; synchronous, active-high
- iXValid  in  1  logit element valid
- oXReady  out  1  logit element accepted when iXValid && oXReady
- iXData  in  16  signed Q7.8 logit (x_i − max)
- iXLast  in  1  marks last element of the vector
- iLnValid  in  1  ln(sum) valid
- oLnReady  out  1  ln(sum) accepted when iLnValid && oLnReady
- iLnData  in  16  signed Q7.8 ln(sum)
- oValid  out  1  output element valid
- iReady  in  1  downstream ready
- oData  out  16  signed Q7.8 normalised log-probability
- oLast  out  1  marks last output element of the vector
- oErr  out  1  sticky overflow flag (vector longer than VEC_LEN)

Behaviour:
- Reset (iRst=1 at a clock edge):
  - oValid=0, oLast=0, oData=0, oErr=0.
  - Write/read pointers=0, count=0, rLnHeld=0, state=S_FILL.
  - A partial vector or drain in progress is discarded.
- State S_FILL:
  - oXReady=1.
  - Each accepted element is written to buf[wptr]; wptr increments.
  - When iXLast is accepted, record cnt=wptr+1 and go to S_WAIT.
  - Forced last: if element index VEC_LEN−1 is accepted without iXLast, treat it as last and set oErr=1. oErr holds until reset.
- State S_WAIT:
  - oXReady=0.
  - Go to S_DRAIN on the cycle after rLnHeld=1, or immediately next cycle if ln was already held when the last x was accepted.
- ln capture:
  - oLnReady = !rLnHeld && state != S_DRAIN.
  - ln may be accepted in S_FILL or S_WAIT and is held in rLn.
  - ln accepted in the same cycle as the last x: both are captured, and the state is S_DRAIN on the next cycle.
- State S_DRAIN:
  - oXReady=0, oLnReady=0.
  - The output register loads when !oValid || iReady. On load: oData = sat16(buf[rptr] − rLn), oLast = (rptr == cnt−1), rptr increments.
  - After the last element loads: go to S_FILL, clear rLnHeld, reset wptr and rptr.
  - A new vector may be accepted while the final output is still stalled.
- Output handshake:
  - oValid stays asserted until iReady.
  - oData and oLast are stable while oValid && !iReady.
  - Throughput is 1 element/cycle when iReady=1.
- Latency: first oValid asserts 2 cycles after the edge that completes fill+ln (1 cycle state change, 1 cycle output register).
- Arithmetic:
  - diff = 17-bit sign-extended x − ln.
  - sat16: values > 32767 → 0x7FFF; values < −32768 → 0x8000.
  - No rounding; formats are already aligned.

Optional Feature:
- Macro: LNSUB_FLOOR_CLAMP_EN.
- Defined: after sat16, any result below −16.0 (0xF000) is clamped to 0xF000. This keeps the downstream exp LUT in range; exp(−16) ≈ 0 in output precision.
- Undefined: only 16-bit saturation applies.

Test Plan:
- Basic vector: x = 0x0000, 0xFF00, 0xFE00 (last on third); ln = 0x0068 sent after the last x → oData = 0xFF98, 0xFE98, 0xFD98; oLast only on the third; first oValid 2 cycles after ln accept.
- Early ln / simultaneous: ln = 0x0068 sent before the first x → oLnReady drops the cycle after accept and stays low until the drain completes. Repeat with ln and the last x in the same cycle → identical outputs.
- Backpressure: iReady held low 5 cycles after the first output → oData = 0xFF98 stable, no element lost or duplicated; remaining outputs follow in order.
- Saturation: x = 0x8000, ln = 0x0100 → oData = 0x8000 without macro, 0xF000 with LNSUB_FLOOR_CLAMP_EN. Also x = 0xF800, ln = 0x0000 → 0xF800 in both builds.
- Overflow: VEC_LEN=4 instance, 4 elements sent with no iXLast → oXReady=0 after the 4th, oErr=1, 4 outputs with oLast on the 4th. oErr remains 1 through the next normal vector.
- Reset mid-drain: iRst pulsed after 1 of 3 outputs → oValid=0 next cycle, oErr=0, state S_FILL; a fresh vector then produces correct outputs.

Source files
------------

// File: rtl/ln_sub_norm.sv
// Log-domain softmax normaliser: buffers one vector of (x - max), then streams (x - max) - ln(sum).
// Optional build macro LNSUB_FLOOR_CLAMP_EN clamps results below -16.0 to 0xF000.
module ln_sub_norm #(
    parameter int VEC_LEN = 64,
    parameter int ADDR_W  = 6
) (
    input  logic        iClk,
    input  logic        iRst,
    input  logic        iXValid,
    output logic        oXReady,
    input  logic [15:0] iXData,
    input  logic        iXLast,
    input  logic        iLnValid,
    output logic        oLnReady,
    input  logic [15:0] iLnData,
    output logic        oValid,
    input  logic        iReady,
    output logic [15:0] oData,
    output logic        oLast,
    output logic        oErr,
    output logic [1:0]  oState
);

    // Valid/ready: a transfer happens on a rising edge where valid && ready; a
    // source holds data stable while valid && !ready.

    typedef enum logic [1:0] {
        S_FILL  = 2'd0,
        S_WAIT  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(VEC_LEN - 1);
    localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);

    state_t            state;
    state_t            state_nxt;
    logic [15:0]       mem [VEC_LEN];
    logic [ADDR_W-1:0] wptr;
    logic [ADDR_W-1:0] rptr;
    logic [ADDR_W-1:0] rLastIdx;
    logic              rLnHeld;
    logic [15:0]       rLn;

    logic              x_fire;
    logic              ln_fire;
    logic              x_at_end;
    logic              x_done;
    logic              x_forced;
    logic              out_load;
    logic              load_last;
    logic [15:0]       rd_x;
    logic [16:0]       diff;
    logic [15:0]       sat;
    logic [15:0]       res;

    assign oXReady  = (state == S_FILL);
    assign oLnReady = !rLnHeld && (state != S_DRAIN);
    assign oState   = state;

    assign x_fire    = iXValid && oXReady;
    assign ln_fire   = iLnValid && oLnReady;
    assign x_at_end  = (wptr == LAST_IDX);
    assign x_done    = x_fire && (iXLast || x_at_end);
    assign x_forced  = x_fire && !iXLast && x_at_end;
    assign out_load  = (state == S_DRAIN) && (!oValid || iReady);
    assign load_last = out_load && (rptr == rLastIdx);

    // Formats are aligned, so a 17-bit difference followed by saturation is exact.
    always_comb begin
        rd_x = mem[rptr];
        diff = {rd_x[15], rd_x} - {rLn[15], rLn};
        sat  = diff[15:0];
        if (diff[16] != diff[15]) begin
            sat = diff[16] ? 16'h8000 : 16'h7FFF;
        end
`ifdef LNSUB_FLOOR_CLAMP_EN
        res = ($signed(sat) < $signed(16'hF000)) ? 16'hF000 : sat;
`else
        res = sat;
`endif
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_FILL: begin
                if (x_done) begin
                    state_nxt = (rLnHeld || ln_fire) ? S_DRAIN : S_WAIT;
                end
            end
            S_WAIT: begin
                if (rLnHeld) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (load_last) begin
                    state_nxt = S_FILL;
                end
            end
            default: state_nxt = S_FILL;
        endcase
    end

    // Buffer has no reset so it can map onto plain memory.
    always_ff @(posedge iClk) begin
        if (x_fire) begin
            mem[wptr] <= iXData;
        end
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state    <= S_FILL;
            wptr     <= '0;
            rptr     <= '0;
            rLastIdx <= '0;
            rLnHeld  <= 1'b0;
            rLn      <= '0;
            oValid   <= 1'b0;
            oData    <= '0;
            oLast    <= 1'b0;
            oErr     <= 1'b0;
        end else begin
            state <= state_nxt;
            if (x_fire) begin
                wptr <= x_done ? '0 : wptr + ONE;
                if (x_done) begin
                    rLastIdx <= wptr;
                end
            end
            if (x_forced) begin
                oErr <= 1'b1;
            end
            if (ln_fire) begin
                rLn     <= iLnData;
                rLnHeld <= 1'b1;
            end
            if (out_load) begin
                oValid <= 1'b1;
                oData  <= res;
                oLast  <= load_last;
                rptr   <= load_last ? '0 : rptr + ONE;
                if (load_last) begin
                    rLnHeld <= 1'b0;
                end
            end else if (iReady) begin
                oValid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ln_sub_norm.sv
// Directed bench for ln_sub_norm: a 64-deep instance (a_*) and a 4-deep instance (b_*) for overflow.
module tb_ln_sub_norm;

    logic        clk;
    logic        rst;

    logic        a_xv, a_xl, a_lv, a_rdy;
    logic [15:0] a_xd, a_ld;
    logic        a_x_ready, a_ln_ready, a_valid, a_last, a_err;
    logic [15:0] a_data;
    logic [1:0]  a_state;

    logic        b_xv, b_xl, b_lv, b_rdy;
    logic [15:0] b_xd, b_ld;
    logic        b_x_ready, b_ln_ready, b_valid, b_last, b_err;
    logic [15:0] b_data;
    logic [1:0]  b_state;

    logic [16:0] exp_a[$];
    logic [16:0] exp_b[$];

    int n_checks;
    int n_fail;

    ln_sub_norm u_dut_a (
        .iClk(clk), .iRst(rst),
        .iXValid(a_xv), .oXReady(a_x_ready), .iXData(a_xd), .iXLast(a_xl),
        .iLnValid(a_lv), .oLnReady(a_ln_ready), .iLnData(a_ld),
        .oValid(a_valid), .iReady(a_rdy), .oData(a_data), .oLast(a_last),
        .oErr(a_err), .oState(a_state)
    );

    ln_sub_norm #(.VEC_LEN(4), .ADDR_W(2)) u_dut_b (
        .iClk(clk), .iRst(rst),
        .iXValid(b_xv), .oXReady(b_x_ready), .iXData(b_xd), .iXLast(b_xl),
        .iLnValid(b_lv), .oLnReady(b_ln_ready), .iLnData(b_ld),
        .oValid(b_valid), .iReady(b_rdy), .oData(b_data), .oLast(b_last),
        .oErr(b_err), .oState(b_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // scoreboard: outputs are compared at the negedge before the transfer edge
    always @(negedge clk) begin
        if (!rst && a_valid && a_rdy) begin
            if (exp_a.size() == 0) begin
                check_eq("a_extra_out", 0, 1);
            end else begin
                logic [16:0] e;
                e = exp_a.pop_front();
                check_eq("a_data", {16'h0, a_data}, {16'h0, e[15:0]});
                check_eq("a_last", {31'h0, a_last}, {31'h0, e[16]});
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && b_valid && b_rdy) begin
            if (exp_b.size() == 0) begin
                check_eq("b_extra_out", 0, 1);
            end else begin
                logic [16:0] e;
                e = exp_b.pop_front();
                check_eq("b_data", {16'h0, b_data}, {16'h0, e[15:0]});
                check_eq("b_last", {31'h0, b_last}, {31'h0, e[16]});
            end
        end
    end

    // driver tasks: inputs change 1ns after the rising edge
    task automatic send_x(input bit sel, input logic [15:0] d, input bit last);
        bit ok;
        ok = 1'b0;
        if (!sel) begin a_xv = 1'b1; a_xd = d; a_xl = last; end
        else      begin b_xv = 1'b1; b_xd = d; b_xl = last; end
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            ok = sel ? b_x_ready : a_x_ready;
            @(posedge clk); #1;
        end
        a_xv = 1'b0; a_xl = 1'b0; b_xv = 1'b0; b_xl = 1'b0;
        check_eq(sel ? "b_x_accept" : "a_x_accept", {31'h0, ok}, 1);
    endtask

    task automatic send_ln(input bit sel, input logic [15:0] d);
        bit ok;
        ok = 1'b0;
        if (!sel) begin a_lv = 1'b1; a_ld = d; end
        else      begin b_lv = 1'b1; b_ld = d; end
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            ok = sel ? b_ln_ready : a_ln_ready;
            @(posedge clk); #1;
        end
        a_lv = 1'b0; b_lv = 1'b0;
        check_eq(sel ? "b_ln_accept" : "a_ln_accept", {31'h0, ok}, 1);
    endtask

    task automatic send_x_ln_same(input logic [15:0] d, input logic [15:0] ln);
        bit ok;
        ok = 1'b0;
        a_xv = 1'b1; a_xd = d; a_xl = 1'b1; a_lv = 1'b1; a_ld = ln;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            ok = a_x_ready && a_ln_ready;
            @(posedge clk); #1;
        end
        a_xv = 1'b0; a_xl = 1'b0; a_lv = 1'b0;
        check_eq("same_accept", {31'h0, ok}, 1);
    endtask

    task automatic wait_drain(input bit sel);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if ((sel ? exp_b.size() : exp_a.size()) == 0) break;
        end
        check_eq(sel ? "b_drain_done" : "a_drain_done", sel ? exp_b.size() : exp_a.size(), 0);
        @(posedge clk); #1;
    endtask

    task automatic wait_valid_a();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (a_valid) break;
        end
        check_eq("a_valid_seen", {31'h0, a_valid}, 1);
    endtask

    task automatic push_basic_exp();
        exp_a.push_back({1'b0, 16'hFF98});
        exp_a.push_back({1'b0, 16'hFE98});
        exp_a.push_back({1'b1, 16'hFD98});
    endtask

    task automatic send_basic_x();
        send_x(0, 16'h0000, 0);
        send_x(0, 16'hFF00, 0);
        send_x(0, 16'hFE00, 1);
    endtask

    initial begin
        logic [15:0] sat_lo;
`ifdef LNSUB_FLOOR_CLAMP_EN
        sat_lo = 16'hF000;
`else
        sat_lo = 16'h8000;
`endif
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1;
        a_xv = 0; a_xl = 0; a_lv = 0; a_rdy = 1; a_xd = '0; a_ld = '0;
        b_xv = 0; b_xl = 0; b_lv = 0; b_rdy = 1; b_xd = '0; b_ld = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // reset state
        @(negedge clk);
        check_eq("rst_valid", {31'h0, a_valid}, 0);
        check_eq("rst_last", {31'h0, a_last}, 0);
        check_eq("rst_data", {16'h0, a_data}, 0);
        check_eq("rst_err", {31'h0, a_err}, 0);
        check_eq("rst_state", {30'h0, a_state}, 0);
        check_eq("rst_x_ready", {31'h0, a_x_ready}, 1);
        check_eq("rst_ln_ready", {31'h0, a_ln_ready}, 1);
        @(posedge clk); #1;

        // basic vector, ln after last x, latency check
        push_basic_exp();
        send_basic_x();
        send_ln(0, 16'h0068);
        @(negedge clk); check_eq("lat_c0", {31'h0, a_valid}, 0);
        @(negedge clk); check_eq("lat_c1", {31'h0, a_valid}, 0);
        @(negedge clk); check_eq("lat_c2", {31'h0, a_valid}, 1);
        @(posedge clk); #1;
        wait_drain(0);

        // early ln
        push_basic_exp();
        send_ln(0, 16'h0068);
        @(negedge clk); check_eq("early_ln_ready_drop", {31'h0, a_ln_ready}, 0);
        @(posedge clk); #1;
        send_basic_x();
        @(negedge clk); check_eq("early_ln_ready_low", {31'h0, a_ln_ready}, 0);
        @(posedge clk); #1;
        wait_drain(0);
        @(negedge clk); check_eq("early_ln_ready_back", {31'h0, a_ln_ready}, 1);
        @(posedge clk); #1;

        // ln and last x in the same cycle
        push_basic_exp();
        send_x(0, 16'h0000, 0);
        send_x(0, 16'hFF00, 0);
        send_x_ln_same(16'hFE00, 16'h0068);
        @(negedge clk); check_eq("same_state_drain", {30'h0, a_state}, 2);
        @(posedge clk); #1;
        wait_drain(0);

        // backpressure on the first output
        a_rdy = 1'b0;
        push_basic_exp();
        send_basic_x();
        send_ln(0, 16'h0068);
        wait_valid_a();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check_eq("bp_valid", {31'h0, a_valid}, 1);
            check_eq("bp_data", {16'h0, a_data}, 32'hFF98);
            check_eq("bp_last", {31'h0, a_last}, 0);
        end
        @(posedge clk); #1;
        a_rdy = 1'b1;
        wait_drain(0);

        // saturation
        exp_a.push_back({1'b1, sat_lo});
        send_x(0, 16'h8000, 1);
        send_ln(0, 16'h0100);
        wait_drain(0);
        exp_a.push_back({1'b0, 16'h7FFF});
        exp_a.push_back({1'b1, 16'hF900});
        send_x(0, 16'h7FFF, 0);
        send_x(0, 16'hF800, 1);
        send_ln(0, 16'hFF00);
        wait_drain(0);
        exp_a.push_back({1'b1, 16'hF800});
        send_x(0, 16'hF800, 1);
        send_ln(0, 16'h0000);
        wait_drain(0);
        @(negedge clk); check_eq("a_err_clear", {31'h0, a_err}, 0);
        @(posedge clk); #1;

        // overflow on the 4-deep instance
        exp_b.push_back({1'b0, 16'h0000});
        exp_b.push_back({1'b0, 16'h0010});
        exp_b.push_back({1'b0, 16'h0020});
        exp_b.push_back({1'b1, 16'h0030});
        send_x(1, 16'h0010, 0);
        send_x(1, 16'h0020, 0);
        send_x(1, 16'h0030, 0);
        send_x(1, 16'h0040, 0);
        @(negedge clk);
        check_eq("ovf_x_ready", {31'h0, b_x_ready}, 0);
        check_eq("ovf_err", {31'h0, b_err}, 1);
        @(posedge clk); #1;
        send_ln(1, 16'h0010);
        wait_drain(1);
        exp_b.push_back({1'b1, 16'h0100});
        send_x(1, 16'h0100, 1);
        send_ln(1, 16'h0000);
        wait_drain(1);
        @(negedge clk); check_eq("ovf_err_sticky", {31'h0, b_err}, 1);
        @(posedge clk); #1;

        // reset in the middle of a drain
        exp_a.push_back({1'b0, 16'hFF98});
        send_basic_x();
        send_ln(0, 16'h0068);
        wait_valid_a();
        @(posedge clk); #1;
        rst = 1'b1;
        a_rdy = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_eq("mid_rst_valid", {31'h0, a_valid}, 0);
        check_eq("mid_rst_err", {31'h0, a_err}, 0);
        check_eq("mid_rst_state", {30'h0, a_state}, 0);
        check_eq("mid_rst_b_err", {31'h0, b_err}, 0);
        check_eq("mid_rst_q", exp_a.size(), 0);
        @(posedge clk); #1;
        a_rdy = 1'b1;
        push_basic_exp();
        send_basic_x();
        send_ln(0, 16'h0068);
        wait_drain(0);

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
